// File: rtl/idu_pipe.sv
// Pipelined instruction decode unit: decodes one instruction per cycle into a
// single-entry output register with valid/ready handshake, flush, counter and sticky error.
module idu_pipe #(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 4,
  parameter int REG_W   = 2,
  parameter int IMM_W   = 8,
  parameter int DATA_W  = 8,
  parameter int NUM_OPS = 12,
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               flush_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [NUM_OPS-1:0] op_o,
  output logic               illegal_o,
  output logic [DATA_W-1:0]  imm_o,
  output logic [REG_W-1:0]   src_reg_o,
  output logic [REG_W-1:0]   dst_reg_o,
  output logic [COUNT_W-1:0] dec_count_o,
  output logic               err_o
);

  logic [OPC_W-1:0]   opcode;
  logic [REG_W-1:0]   dst_fld;
  logic [REG_W-1:0]   src_fld;
  logic [IMM_W-1:0]   imm_fld;
  logic [NUM_OPS-1:0] dec_op;
  logic               dec_illegal;
  logic               dec_sext;
  logic [DATA_W-1:0]  dec_imm;
  logic               accept;
  logic               xfer;

  assign opcode  = instr_i[INSTR_W-1 -: OPC_W];
  assign dst_fld = instr_i[IMM_W+REG_W +: REG_W];
  assign src_fld = instr_i[IMM_W +: REG_W];
  assign imm_fld = instr_i[IMM_W-1:0];

  assign dec_illegal = 32'(opcode) >= 32'(NUM_OPS);

  // One-hot decode; an illegal opcode matches no bit so op stays all-zero.
  always_comb begin
    dec_op = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      if (32'(opcode) == 32'(k)) dec_op[k] = 1'b1;
    end
  end

  // Only addi (4) and cmpeqi (7) take a signed immediate.
  assign dec_sext = !dec_illegal && (32'(opcode) == 32'd4 || 32'(opcode) == 32'd7);
  assign dec_imm  = dec_sext ? DATA_W'($signed(imm_fld)) : DATA_W'(imm_fld);

  assign in_ready_o = !flush_i && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign xfer       = out_valid_o && out_ready_i;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_o <= 1'b0;
      op_o        <= '0;
      illegal_o   <= 1'b0;
      imm_o       <= '0;
      src_reg_o   <= '0;
      dst_reg_o   <= '0;
      dec_count_o <= '0;
      err_o       <= 1'b0;
    end else begin
      if (xfer) begin
        dec_count_o <= dec_count_o + 1'b1;
        if (illegal_o) err_o <= 1'b1;
      end
      // Flush wins; accept is already blocked by in_ready_o during a flush.
      if (flush_i) begin
        out_valid_o <= 1'b0;
      end else if (accept) begin
        out_valid_o <= 1'b1;
        op_o        <= dec_op;
        illegal_o   <= dec_illegal;
        imm_o       <= dec_imm;
        src_reg_o   <= src_fld;
        dst_reg_o   <= dst_fld;
      end else if (xfer) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_idu_pipe.sv
// Bench for idu_pipe: default instance plus a DATA_W=16 / COUNT_W=4 instance on shared inputs,
// checked every cycle against a queue-based scoreboard and a constant vector table.
module tb_idu_pipe;

  typedef struct {
    logic [15:0] instr;
    logic [11:0] op;
    logic        illegal;
    logic [15:0] imm;
    logic [1:0]  src;
    logic [1:0]  dst;
  } exp_t;

  logic        clock;
  logic        reset_n;
  logic [15:0] instr;
  logic        in_valid;
  logic        out_ready;
  logic        flush;

  logic        in_ready_a, out_valid_a, illegal_a, err_a;
  logic [11:0] op_a;
  logic [7:0]  imm_a;
  logic [1:0]  src_a, dst_a;
  logic [15:0] count_a;

  logic        in_ready_b, out_valid_b, illegal_b, err_b;
  logic [11:0] op_b;
  logic [15:0] imm_b;
  logic [1:0]  src_b, dst_b;
  logic [3:0]  count_b;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [15:0] m_count = 16'd0;
  logic        m_err = 1'b0;

  idu_pipe u_dut (
    .clock(clock), .reset_n(reset_n), .instr_i(instr), .in_valid_i(in_valid),
    .in_ready_o(in_ready_a), .flush_i(flush), .out_valid_o(out_valid_a),
    .out_ready_i(out_ready), .op_o(op_a), .illegal_o(illegal_a), .imm_o(imm_a),
    .src_reg_o(src_a), .dst_reg_o(dst_a), .dec_count_o(count_a), .err_o(err_a)
  );

  idu_pipe #(.DATA_W(16), .COUNT_W(4)) u_dut_w (
    .clock(clock), .reset_n(reset_n), .instr_i(instr), .in_valid_i(in_valid),
    .in_ready_o(in_ready_b), .flush_i(flush), .out_valid_o(out_valid_b),
    .out_ready_i(out_ready), .op_o(op_b), .illegal_o(illegal_b), .imm_o(imm_b),
    .src_reg_o(src_b), .dst_reg_o(dst_b), .dec_count_o(count_b), .err_o(err_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_decode(input logic [15:0] ins);
    exp_t       e;
    logic [3:0] opc;
    opc       = ins[15:12];
    e.instr   = ins;
    e.illegal = opc >= 4'd12;
    e.op      = e.illegal ? 12'h000 : (12'h001 << opc);
    e.imm     = (opc == 4'd4 || opc == 4'd7) ? {{8{ins[7]}}, ins[7:0]} : {8'h00, ins[7:0]};
    e.dst     = ins[11:10];
    e.src     = ins[9:8];
    return e;
  endfunction

  task automatic check_output(input logic exp_ready);
    logic v;
    v = sb.size() != 0;
    chk("in_ready", 32'(in_ready_a), 32'(exp_ready));
    chk("in_ready_w", 32'(in_ready_b), 32'(exp_ready));
    chk("out_valid", 32'(out_valid_a), 32'(v));
    chk("out_valid_w", 32'(out_valid_b), 32'(v));
    if (v) begin
      chk("op", 32'(op_a), 32'(sb[0].op));
      chk("op_w", 32'(op_b), 32'(sb[0].op));
      chk("illegal", 32'(illegal_a), 32'(sb[0].illegal));
      chk("illegal_w", 32'(illegal_b), 32'(sb[0].illegal));
      chk("imm", 32'(imm_a), 32'(sb[0].imm[7:0]));
      chk("imm_w", 32'(imm_b), 32'(sb[0].imm));
      chk("src", 32'(src_a), 32'(sb[0].src));
      chk("dst", 32'(dst_a), 32'(sb[0].dst));
      chk("src_w", 32'(src_b), 32'(sb[0].src));
      chk("dst_w", 32'(dst_b), 32'(sb[0].dst));
    end
    chk("dec_count", 32'(count_a), 32'(m_count));
    chk("dec_count_w", 32'(count_b), 32'(m_count[3:0]));
    chk("err", 32'(err_a), 32'(m_err));
    chk("err_w", 32'(err_b), 32'(m_err));
  endtask

  task automatic check_reset();
    chk("rst_out_valid", 32'(out_valid_a | out_valid_b), 32'd0);
    chk("rst_op", 32'(op_a | op_b), 32'd0);
    chk("rst_illegal", 32'(illegal_a | illegal_b), 32'd0);
    chk("rst_imm", 32'(imm_b | {8'h00, imm_a}), 32'd0);
    chk("rst_regs", 32'({src_a, dst_a, src_b, dst_b}), 32'd0);
    chk("rst_count", 32'(count_a), 32'd0);
    chk("rst_count_w", 32'(count_b), 32'd0);
    chk("rst_err", 32'(err_a | err_b), 32'd0);
    chk("rst_in_ready", 32'(in_ready_a & in_ready_b), 32'(!flush));
  endtask

  // Drives one cycle from just after a rising edge, checks before the next, then steps the model.
  task automatic apply_stimulus(input logic [15:0] i_instr, input logic i_valid,
                                input logic i_ready, input logic i_flush,
                                input exp_t e, output logic accepted);
    logic m_ready, xfer;
    instr     = i_instr;
    in_valid  = i_valid;
    out_ready = i_ready;
    flush     = i_flush;
    #2;
    m_ready = !i_flush && (sb.size() == 0 || i_ready);
    check_output(m_ready);
    accepted = i_valid && m_ready;
    xfer     = sb.size() != 0 && i_ready;
    @(posedge clock);
    #1;
    if (xfer) begin
      m_count++;
      if (sb[0].illegal) m_err = 1'b1;
      void'(sb.pop_front());
    end
    if (i_flush) sb.delete();
    if (accepted) sb.push_back(e);
  endtask

  task automatic step(input logic [15:0] i_instr, input logic i_valid,
                      input logic i_ready, input logic i_flush);
    logic acc;
    apply_stimulus(i_instr, i_valid, i_ready, i_flush, model_decode(i_instr), acc);
  endtask

  initial begin
    exp_t        vec[9];
    logic [15:0] stream[8];
    logic        acc;
    int          idx;
    logic [15:0] base;

    vec[0] = '{16'h41F0, 12'h010, 1'b0, 16'hFFF0, 2'd1, 2'd0};
    vec[1] = '{16'hB6F0, 12'h800, 1'b0, 16'h00F0, 2'd2, 2'd1};
    vec[2] = '{16'hF123, 12'h000, 1'b1, 16'h0023, 2'd1, 2'd0};
    vec[3] = '{16'h7E80, 12'h080, 1'b0, 16'hFF80, 2'd2, 2'd3};
    vec[4] = '{16'h0C7F, 12'h001, 1'b0, 16'h007F, 2'd0, 2'd3};
    vec[5] = '{16'h3981, 12'h008, 1'b0, 16'h0081, 2'd1, 2'd2};
    vec[6] = '{16'hC2FF, 12'h000, 1'b1, 16'h00FF, 2'd2, 2'd0};
    vec[7] = '{16'h4A7F, 12'h010, 1'b0, 16'h007F, 2'd2, 2'd2};
    vec[8] = '{16'hA5AA, 12'h400, 1'b0, 16'h00AA, 2'd1, 2'd1};

    reset_n = 1'b0; instr = '0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset();
    reset_n = 1'b1;

    $display("[TB] vector table, full throughput");
    for (int i = 0; i < 9; i++) apply_stimulus(vec[i].instr, 1'b1, 1'b1, 1'b0, vec[i], acc);
    step(16'h0000, 1'b0, 1'b1, 1'b0);
    step(16'h0000, 1'b0, 1'b1, 1'b0);
    chk("table_count", 32'(count_a), 32'd9);
    chk("err_sticky", 32'(err_a), 32'd1);

    $display("[TB] stream of 8 with 3-cycle stall");
    for (int i = 0; i < 8; i++) stream[i] = 16'($urandom);
    base = m_count;
    idx = 0;
    for (int c = 0; c < 40 && (idx < 8 || sb.size() != 0); c++) begin
      apply_stimulus(stream[idx % 8], idx < 8, !(c >= 3 && c < 6), 1'b0,
                     model_decode(stream[idx % 8]), acc);
      if (acc) idx++;
    end
    chk("stream_all_accepted", 32'(idx), 32'd8);
    chk("stream_drained", 32'(sb.size()), 32'd0);
    chk("stream_count", 32'(count_a), 32'(base + 16'd8));

    $display("[TB] flush of a stalled entry");
    step(16'h3400, 1'b1, 1'b0, 1'b0);
    step(16'h0000, 1'b0, 1'b0, 1'b0);
    base = m_count;
    step(16'h5500, 1'b1, 1'b0, 1'b1);
    step(16'h0000, 1'b0, 1'b1, 1'b0);
    chk("flush_count_hold", 32'(count_a), 32'(base));

    $display("[TB] flush concurrent with transfer");
    step(16'hF000, 1'b1, 1'b0, 1'b0);
    base = m_count;
    step(16'h2100, 1'b1, 1'b1, 1'b1);
    step(16'h0000, 1'b0, 1'b1, 1'b0);
    chk("flush_xfer_count", 32'(count_a), 32'(base + 16'd1));

    $display("[TB] reset mid-stall");
    step(16'hF3AB, 1'b1, 1'b0, 1'b0);
    step(16'h0000, 1'b0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset();
    sb.delete();
    m_count = 16'd0;
    m_err   = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    $display("[TB] counter wrap");
    for (int i = 0; i < 17; i++) step(16'($urandom), 1'b1, 1'b1, 1'b0);
    step(16'h0000, 1'b0, 1'b1, 1'b0);
    step(16'h0000, 1'b0, 1'b1, 1'b0);
    chk("wrap_count_w", 32'(count_b), 32'd1);
    chk("wrap_count", 32'(count_a), 32'd17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
